// File: rtl/pio_pkg.sv
// Shared definitions for the PIO family: register addresses, STATUS bit
// positions and the bus write-decode helper.
package pio_pkg;

    // Word addresses of the register map
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_SET      = 3'd4;
    localparam logic [2:0] ADDR_CLEAR    = 3'd5;

    // STATUS register bit positions
    localparam int STATUS_PHASE_BIT  = 0;
    localparam int STATUS_ACTIVE_BIT = 1;

    // A bus write happens when the slave is selected and the strobe is low
    function automatic logic is_write(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/pio_out_blink_if.sv
// Avalon-MM slave bus bundle for the output PIO.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit read data, zero wait states
interface pio_out_blink_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_blink_prescaler.sv
// Free-running prescaler that toggles a phase bit every PERIOD+1 clocks.
// A zero period parks the engine with phase = 1; restart reloads cnt = 0
// and phase = 1 and takes priority over a wrap in the same cycle.
//   clk, reset_n : clock and asynchronous active-low reset
//   period       : half-period in clocks minus 1
//   restart      : reload request (asserted in the cycle period is written)
//   phase        : current blink phase (registered)
//   active       : period is non-zero
module pio_blink_prescaler #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period,
    input  logic             restart,
    output logic             phase,
    output logic             active
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             phase_q;
    logic             phase_d;
    logic             active_s;

    assign active_s = (period != {CNT_W{1'b0}});

    // Next-state logic for the counter and phase
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = 1'b1;
        end else if (!active_s) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = 1'b1;
        end else if (cnt_q == period) begin
            cnt_d   = {CNT_W{1'b0}};
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end
    end

    // Counter and phase registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= {CNT_W{1'b0}};
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase  = phase_q;
    assign active = active_s;

endmodule

// File: rtl/pio_out_blink.sv
// Parametrised Avalon-MM output PIO with atomic SET/CLEAR and a per-bit
// hardware blink engine.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port     : registered output pins
// Register map: 0 DATA, 1 BLINK_EN, 2 PERIOD, 3 STATUS (RO), 4 SET (WO),
// 5 CLEAR (WO), 6-7 reserved. readdata is combinational and shows the
// pre-edge register contents even during a write.
module pio_out_blink
    import pio_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               CNT_W        = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
    parameter logic [CNT_W-1:0] RESET_PERIOD = {CNT_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_out_blink_if.slave   bus,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] blink_en_q;
    logic [WIDTH-1:0] blink_en_d;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_d;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    logic             wr_s;
    logic             restart_s;
    logic             phase_s;
    logic             active_s;
    logic [WIDTH-1:0] wd_s;
    logic [CNT_W-1:0] wd_cnt_s;
    logic [31:0]      rd_s;
    logic             unused_wd_s;

    assign wr_s     = is_write(bus.chipselect, bus.write_n);
    assign wd_s     = bus.writedata[WIDTH-1:0];
    assign wd_cnt_s = bus.writedata[CNT_W-1:0];
    // Upper writedata bits are deliberately ignored for narrow registers
    assign unused_wd_s = ^bus.writedata;

    // Register-file write decode
    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        restart_s  = 1'b0;
        if (wr_s) begin
            case (bus.address)
                ADDR_DATA:     data_d     = wd_s;
                ADDR_BLINK_EN: blink_en_d = wd_s;
                ADDR_PERIOD: begin
                    period_d  = wd_cnt_s;
                    restart_s = 1'b1;
                end
                ADDR_SET:      data_d     = data_q | wd_s;
                ADDR_CLEAR:    data_d     = data_q & ~wd_s;
                default:       data_d     = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    pio_blink_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_q),
        .restart (restart_s),
        .phase   (phase_s),
        .active  (active_s)
    );

    // Blinking bits are forced low during the off phase
    always_comb begin
        out_d = data_q & ~(blink_en_q & {WIDTH{~phase_s}});
    end

    // Read mux, zero-extended to the bus width
    always_comb begin
        rd_s = 32'd0;
        case (bus.address)
            ADDR_DATA:     rd_s[WIDTH-1:0] = data_q;
            ADDR_BLINK_EN: rd_s[WIDTH-1:0] = blink_en_q;
            ADDR_PERIOD:   rd_s[CNT_W-1:0] = period_q;
            ADDR_STATUS: begin
                rd_s[STATUS_PHASE_BIT]  = phase_s;
                rd_s[STATUS_ACTIVE_BIT] = active_s;
            end
            default:       rd_s = 32'd0;
        endcase
    end

    // Register file and output pin registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= {WIDTH{1'b0}};
            period_q   <= RESET_PERIOD;
            out_q      <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            out_q      <= out_d;
        end
    end

    assign bus.readdata = rd_s;
    assign out_port     = out_q;

endmodule
